// File: rtl/rf_wb_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_sequencer_pkg
//  Description : Shared defaults and source encoding for the register-file
//                writeback sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package rf_wb_sequencer_pkg;

  localparam int c_awl_default   = 5;   // 32 registers
  localparam int c_dwl_default   = 16;
  localparam int c_depth_default = 4;

  // Producer identity, used for the round-robin history bit.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

endpackage
`default_nettype wire

// File: rtl/rf_wb_sequencer_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_sequencer_wb_fifo
//  Description : Small writeback FIFO of {addr,data} entries. Exposes the
//                entries in age order (oldest first) with a valid mask so the
//                parent can scan queued writes for forwarding.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_wb_sequencer_wb_fifo #(
  parameter int AWL   = 5,
  parameter int DWL   = 16,
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic [AWL-1:0]                  push_addr,
  input  logic [DWL-1:0]                  push_data,
  input  logic                            pop,
  output logic [$clog2(DEPTH):0]          count,
  output logic [AWL-1:0]                  head_addr,
  output logic [DWL-1:0]                  head_data,
  output logic [DEPTH-1:0][AWL-1:0]       ord_addr,
  output logic [DEPTH-1:0][DWL-1:0]       ord_data,
  output logic [DEPTH-1:0]                ord_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AWL-1:0] r_mem_addr;
  logic [DEPTH-1:0][DWL-1:0] r_mem_data;
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_count;

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (push) begin
        r_mem_addr[r_wr_ptr] <= push_addr;
        r_mem_data[r_wr_ptr] <= push_data;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  // Rotate storage into age order: index 0 is the head (oldest entry).
  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    assign ord_addr[k]  = r_mem_addr[r_rd_ptr + PW'(k)];
    assign ord_data[k]  = r_mem_data[r_rd_ptr + PW'(k)];
    assign ord_valid[k] = (CW'(k) < r_count);
  end

  // Stale storage must not leak onto the write port when empty.
  assign head_addr = ord_valid[0] ? ord_addr[0] : '0;
  assign head_data = ord_valid[0] ? ord_data[0] : '0;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/rf_wb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_sequencer
//  Description : Writer-side front end for the register file write port.
//                Arbitrates ALU and LOAD writeback requests (round-robin),
//                filters r0, queues accepted writes and drains one per cycle.
//                Two lookup ports report the youngest queued value per address.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_wb_sequencer
  import rf_wb_sequencer_pkg::*;
#(
  parameter int AWL   = c_awl_default,
  parameter int DWL   = c_dwl_default,
  parameter int DEPTH = c_depth_default
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [AWL-1:0]         alu_addr,
  input  logic [DWL-1:0]         alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [AWL-1:0]         ld_addr,
  input  logic [DWL-1:0]         ld_data,
  input  logic                   rf_stall,
  output logic                   rf_we,
  output logic [AWL-1:0]         rf_wa,
  output logic [DWL-1:0]         rf_wd,
  input  logic [AWL-1:0]         q1_addr,
  output logic                   q1_hit,
  output logic [DWL-1:0]         q1_data,
  input  logic [AWL-1:0]         q2_addr,
  output logic                   q2_hit,
  output logic [DWL-1:0]         q2_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  src_e                      r_rr_last;
  logic                      w_pop;
  logic                      w_space;
  logic                      w_grant_alu;
  logic                      w_grant_ld;
  logic                      w_push;
  logic [AWL-1:0]            w_push_addr;
  logic [DWL-1:0]            w_push_data;
  logic [AWL-1:0]            w_head_addr;
  logic [DWL-1:0]            w_head_data;
  logic [DEPTH-1:0][AWL-1:0] w_ord_addr;
  logic [DEPTH-1:0][DWL-1:0] w_ord_data;
  logic [DEPTH-1:0]          w_ord_valid;
  logic [CW-1:0]             w_count;

  rf_wb_sequencer_wb_fifo #(
    .AWL   (AWL),
    .DWL   (DWL),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_addr (w_push_addr),
    .push_data (w_push_data),
    .pop       (w_pop),
    .count     (w_count),
    .head_addr (w_head_addr),
    .head_data (w_head_data),
    .ord_addr  (w_ord_addr),
    .ord_data  (w_ord_data),
    .ord_valid (w_ord_valid)
  );

  // A pop this cycle frees a slot, so a full FIFO can still accept.
  assign w_pop   = (w_count != '0) & ~rf_stall;
  assign w_space = (w_count < CW'(DEPTH)) | w_pop;

  // Round-robin grant; r0 requests are acknowledged but never enqueued.
  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_ld  = 1'b0;
    if (rst_n && w_space) begin
      if (alu_valid && ld_valid) begin
        if (r_rr_last == SRC_ALU) w_grant_ld  = 1'b1;
        else                      w_grant_alu = 1'b1;
      end else if (alu_valid) begin
        w_grant_alu = 1'b1;
      end else if (ld_valid) begin
        w_grant_ld = 1'b1;
      end
    end
    w_push_addr = w_grant_ld ? ld_addr : alu_addr;
    w_push_data = w_grant_ld ? ld_data : alu_data;
    w_push      = (w_grant_alu | w_grant_ld) & (w_push_addr != '0);
  end

  // Remember the last source that actually enqueued a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_last <= SRC_ALU;
    end else if (w_push) begin
      r_rr_last <= w_grant_ld ? SRC_LD : SRC_ALU;
    end
  end

  // Forwarding lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_ord_valid[k] && (q1_addr != '0) && (w_ord_addr[k] == q1_addr)) begin
        q1_hit  = 1'b1;
        q1_data = w_ord_data[k];
      end
      if (w_ord_valid[k] && (q2_addr != '0) && (w_ord_addr[k] == q2_addr)) begin
        q2_hit  = 1'b1;
        q2_data = w_ord_data[k];
      end
    end
  end

  assign alu_ready = w_grant_alu;
  assign ld_ready  = w_grant_ld;
  assign rf_we     = w_pop;
  assign rf_wa     = w_head_addr;
  assign rf_wd     = w_head_data;
  assign count     = w_count;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wb_sequencer
//  Description : Self-checking bench for rf_wb_sequencer. A queue-based
//                reference model predicts every output each cycle; a simple
//                register file array sits behind the DUT write port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_wb_sequencer;

  localparam int AWL   = 5;
  localparam int DWL   = 16;
  localparam int DEPTH = 4;

  logic           clk;
  logic           rst_n;
  logic           alu_valid, alu_ready;
  logic [AWL-1:0] alu_addr;
  logic [DWL-1:0] alu_data;
  logic           ld_valid, ld_ready;
  logic [AWL-1:0] ld_addr;
  logic [DWL-1:0] ld_data;
  logic           rf_stall;
  logic           rf_we;
  logic [AWL-1:0] rf_wa;
  logic [DWL-1:0] rf_wd;
  logic [AWL-1:0] q1_addr, q2_addr;
  logic           q1_hit, q2_hit;
  logic [DWL-1:0] q1_data, q2_data;
  logic [$clog2(DEPTH):0] count;

  rf_wb_sequencer #(.AWL(AWL), .DWL(DWL), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .rf_stall  (rf_stall),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .q1_addr   (q1_addr),
    .q1_hit    (q1_hit),
    .q1_data   (q1_data),
    .q2_addr   (q2_addr),
    .q2_hit    (q2_hit),
    .q2_data   (q2_data),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  typedef struct {
    logic [AWL-1:0] a;
    logic [DWL-1:0] d;
  } ent_t;

  ent_t           mq[$];
  logic           m_rr_ld;          // 1 when LOAD was the last granted source
  logic [DWL-1:0] ref_ram [32];
  logic [DWL-1:0] dut_ram [32];
  logic [AWL-1:0] tq1, tq2;
  int             n_checks;
  int             n_fail;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_lookup(input logic [AWL-1:0] a, output logic h, output logic [DWL-1:0] d);
    h = 1'b0;
    d = '0;
    if (a != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].a == a) begin
          h = 1'b1;
          d = mq[i].d;
          break;
        end
      end
    end
  endfunction

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model and the register file behind the DUT.
  task automatic step(input logic av, input logic [AWL-1:0] aa, input logic [DWL-1:0] ad,
                      input logic lv, input logic [AWL-1:0] la, input logic [DWL-1:0] ld,
                      input logic st, input logic rs, output logic ga, output logic gl);
    int             cnt;
    logic           we, space, h1, h2;
    logic [DWL-1:0] d1, d2;
    logic [AWL-1:0] ewa;
    logic [DWL-1:0] ewd;
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid  = lv; ld_addr  = la; ld_data  = ld;
    rf_stall  = st; rst_n    = rs;
    q1_addr   = tq1; q2_addr = tq2;
    #1;
    cnt   = mq.size();
    we    = (cnt != 0) && !st;
    space = (cnt < DEPTH) || we;
    ga = 1'b0;
    gl = 1'b0;
    if (rs && space) begin
      if (av && lv) begin
        if (m_rr_ld) ga = 1'b1;
        else         gl = 1'b1;
      end else if (av) ga = 1'b1;
      else if (lv)     gl = 1'b1;
    end
    ewa = (cnt != 0) ? mq[0].a : '0;
    ewd = (cnt != 0) ? mq[0].d : '0;
    model_lookup(tq1, h1, d1);
    model_lookup(tq2, h2, d2);
    check_val("alu_ready", 32'(alu_ready), 32'(ga));
    check_val("ld_ready",  32'(ld_ready),  32'(gl));
    check_val("count",     32'(count),     32'(cnt));
    check_val("rf_we",     32'(rf_we),     32'(we));
    check_val("rf_wa",     32'(rf_wa),     32'(ewa));
    check_val("rf_wd",     32'(rf_wd),     32'(ewd));
    check_val("q1_hit",    32'(q1_hit),    32'(h1));
    check_val("q1_data",   32'(q1_data),   32'(d1));
    check_val("q2_hit",    32'(q2_hit),    32'(h2));
    check_val("q2_data",   32'(q2_data),   32'(d2));
    if (rf_we) dut_ram[rf_wa] = rf_wd;
    if (we) begin
      ref_ram[mq[0].a] = mq[0].d;
      void'(mq.pop_front());
    end
    if (!rs) begin
      mq.delete();
      m_rr_ld = 1'b0;
    end else if (ga && aa != '0) begin
      mq.push_back('{aa, ad});
      m_rr_ld = 1'b0;
    end else if (gl && la != '0) begin
      mq.push_back('{la, ld});
      m_rr_ld = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic st);
    logic ga, gl;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, st, 1, ga, gl);
  endtask

  initial begin
    logic     ga, gl;
    int       ai, li, k;
    logic     apend, lpend;
    logic [AWL-1:0] ra, rl;
    logic [DWL-1:0] rda, rdl;
    logic     rst_r;

    n_checks = 0;
    n_fail   = 0;
    m_rr_ld  = 1'b0;
    tq1 = '0; tq2 = '0;
    rst_n = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0; rf_stall = 1'b0;
    alu_addr = '0; alu_data = '0; ld_addr = '0; ld_data = '0;
    q1_addr = '0; q2_addr = '0;
    for (int i = 0; i < 32; i++) begin
      ref_ram[i] = '0;
      dut_ram[i] = '0;
    end

    // Reset held with an ALU request pending
    for (int i = 0; i < 3; i++) step(1, 3, 16'h00AA, 0, 0, 0, 0, 0, ga, gl);
    mq.delete();
    m_rr_ld = 1'b0;

    // First write after reset appears one cycle later
    step(1, 3, 16'h00AA, 0, 0, 0, 0, 1, ga, gl);
    idle(2, 0);

    // Contention: both producers hold requests until accepted
    ai = 1; li = 5;
    for (int c = 0; c < 10; c++) begin
      step(ai <= 4, AWL'(ai), DWL'(16'h0100 + ai), li <= 8, AWL'(li), DWL'(16'h0200 + li), 0, 1, ga, gl);
      if (ga) ai++;
      if (gl) li++;
    end
    idle(6, 0);

    // Full under stall, then release: fifth push rides on the first pop
    k = 10;
    for (int c = 0; c < 7; c++) begin
      step(k <= 14, AWL'(k), DWL'(16'h0A00 + k), 0, 0, 0, c < 5, 1, ga, gl);
      if (ga) k++;
    end
    idle(6, 0);

    // r0 request acknowledged but discarded
    step(1, 0, 16'hFFFF, 0, 0, 0, 0, 1, ga, gl);
    idle(2, 0);
    check_val("ram_r0", 32'(dut_ram[0]), 32'h0);

    // Forwarding of the youngest queued write
    tq1 = 5'd7; tq2 = 5'd12;
    step(1, 7, 16'h1111, 0, 0, 0, 1, 1, ga, gl);
    step(0, 0, 0, 1, 7, 16'h2222, 1, 1, ga, gl);
    idle(2, 1);
    idle(4, 0);
    check_val("ram_r7", 32'(dut_ram[7]), 32'h2222);

    // Reset while entries are queued under stall
    step(1, 9, 16'h0909, 0, 0, 0, 1, 1, ga, gl);
    step(1, 10, 16'h1010, 0, 0, 0, 1, 1, ga, gl);
    step(0, 0, 0, 1, 11, 16'h1111, 1, 1, ga, gl);
    step(0, 0, 0, 0, 0, 0, 1, 0, ga, gl);
    idle(3, 0);

    // Randomized traffic; producers hold a request until it is accepted
    apend = 1'b0; lpend = 1'b0;
    ra = '0; rl = '0; rda = '0; rdl = '0;
    for (int c = 0; c < 400; c++) begin
      if (!apend && ($urandom % 3 != 0)) begin
        apend = 1'b1; ra = AWL'($urandom % 8); rda = DWL'($urandom);
      end
      if (!lpend && ($urandom % 3 != 0)) begin
        lpend = 1'b1; rl = AWL'($urandom % 8); rdl = DWL'($urandom);
      end
      tq1 = AWL'($urandom % 8);
      tq2 = AWL'($urandom % 8);
      rst_r = ($urandom % 80) != 0;
      step(apend, ra, rda, lpend, rl, rdl, ($urandom % 4) == 0, rst_r, ga, gl);
      if (ga || !rst_r) apend = 1'b0;
      if (gl || !rst_r) lpend = 1'b0;
    end
    idle(8, 0);

    for (int i = 0; i < 32; i++) check_val($sformatf("ram[%0d]", i), 32'(dut_ram[i]), 32'(ref_ram[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
